// File: rtl/ascii_operand_parser.sv
// ASCII front-end for the add/subtract datapath: parses "dd\n dd\n op\n" frames into X, Y and Op.
// Optional macro PARSE_ERR_CNT_EN adds a saturating err_cnt output cleared by an ESC byte.
module ascii_operand_parser #(
  parameter int         WIDTH   = 5,
  parameter int         MAX_VAL = 15,
  parameter logic [7:0] TERM    = 8'h0A
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_x,
  output logic [WIDTH-1:0] out_y,
  output logic             out_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err,
  output logic [1:0]       err_code
`ifdef PARSE_ERR_CNT_EN
  ,
  output logic [7:0]       err_cnt
`endif
);

  typedef enum logic [3:0] {
    X_D1, X_D0, X_NL, Y_D1, Y_D0, Y_NL, OP, OP_NL, EMIT, FLUSH
  } state_t;

  localparam logic [6:0] MaxVal = 7'(MAX_VAL);

  state_t           state_q;
  logic [3:0]       tens_q;
  logic [WIDTH-1:0] xVal_q;
  logic [WIDTH-1:0] yVal_q;
  logic             op_q;
  logic [WIDTH-1:0] outX_q;
  logic [WIDTH-1:0] outY_q;
  logic             outOp_q;
  logic             outValid_q;
  logic             err_q;
  logic [1:0]       errCode_q;

  logic       consume;
  logic       isDigit;
  logic       isTerm;
  logic       isCr;
  logic       isEsc;
  logic       isOpChar;
  logic [3:0] units;
  logic [6:0] value_d;
  logic       errHit_d;
  logic [1:0] errCode_d;

  assign in_ready = !rst && (state_q != EMIT);
  assign consume  = in_valid && in_ready;
  assign isDigit  = (in_data >= 8'h30) && (in_data <= 8'h39);
  assign isTerm   = (in_data == TERM);
  assign isCr     = (in_data == 8'h0D);
  assign isOpChar = (in_data == 8'h2B) || (in_data == 8'h2D);
  assign units    = in_data[3:0];
  // Full 7-bit value so the range check sees 16..99 before truncation to WIDTH.
  assign value_d  = ({3'b000, tens_q} * 7'd10) + {3'b000, units};

`ifdef PARSE_ERR_CNT_EN
  logic [7:0] errCnt_q;
  assign isEsc   = (in_data == 8'h1B);
  assign err_cnt = errCnt_q;
`else
  assign isEsc   = 1'b0;
`endif

  assign out_x     = outX_q;
  assign out_y     = outY_q;
  assign out_op    = outOp_q;
  assign out_valid = outValid_q;
  assign err       = err_q;
  assign err_code  = errCode_q;

  always_comb begin
    errHit_d  = 1'b0;
    errCode_d = 2'd0;
    if (consume && !isCr && !isEsc) begin
      case (state_q)
        X_D1, Y_D1: begin
          if (!isDigit) begin
            errHit_d  = 1'b1;
            errCode_d = 2'd1;
          end
        end
        X_D0, Y_D0: begin
          if (!isDigit) begin
            errHit_d  = 1'b1;
            errCode_d = 2'd1;
          end else if (value_d > MaxVal) begin
            errHit_d  = 1'b1;
            errCode_d = 2'd2;
          end
        end
        X_NL, Y_NL, OP_NL: begin
          if (!isTerm) begin
            errHit_d  = 1'b1;
            errCode_d = 2'd3;
          end
        end
        OP: begin
          if (!isOpChar) begin
            errHit_d  = 1'b1;
            errCode_d = 2'd3;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= X_D1;
      tens_q     <= '0;
      xVal_q     <= '0;
      yVal_q     <= '0;
      op_q       <= 1'b0;
      outX_q     <= '0;
      outY_q     <= '0;
      outOp_q    <= 1'b0;
      outValid_q <= 1'b0;
      err_q      <= 1'b0;
      errCode_q  <= 2'd0;
`ifdef PARSE_ERR_CNT_EN
      errCnt_q   <= 8'd0;
`endif
    end else begin
      err_q <= 1'b0;
      if (errHit_d) begin
        // An offending terminator already marks a field boundary, so no flush is needed.
        err_q     <= 1'b1;
        errCode_q <= errCode_d;
        state_q   <= isTerm ? X_D1 : FLUSH;
`ifdef PARSE_ERR_CNT_EN
        if (errCnt_q != 8'hFF) errCnt_q <= errCnt_q + 8'd1;
`endif
      end else if (consume && isEsc) begin
        state_q <= X_D1;
`ifdef PARSE_ERR_CNT_EN
        errCnt_q <= 8'd0;
`endif
      end else if (consume && !isCr) begin
        case (state_q)
          X_D1: begin
            tens_q  <= units;
            state_q <= X_D0;
          end
          X_D0: begin
            xVal_q  <= WIDTH'(value_d);
            state_q <= X_NL;
          end
          X_NL:  state_q <= Y_D1;
          Y_D1: begin
            tens_q  <= units;
            state_q <= Y_D0;
          end
          Y_D0: begin
            yVal_q  <= WIDTH'(value_d);
            state_q <= Y_NL;
          end
          Y_NL:  state_q <= OP;
          OP: begin
            op_q    <= (in_data == 8'h2D);
            state_q <= OP_NL;
          end
          OP_NL: begin
            outX_q     <= xVal_q;
            outY_q     <= yVal_q;
            outOp_q    <= op_q;
            outValid_q <= 1'b1;
            state_q    <= EMIT;
          end
          FLUSH: begin
            if (isTerm) state_q <= X_D1;
          end
          default: ;
        endcase
      end else if (state_q == EMIT && out_ready) begin
        outValid_q <= 1'b0;
        state_q    <= X_D1;
      end
    end
  end

endmodule

// File: tb/tb_ascii_operand_parser.sv
// Randomized self-checking bench for ascii_operand_parser; expectations come from how each frame is built.
module tb_ascii_operand_parser;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] out_x;
  logic [4:0] out_y;
  logic       out_op;
  logic       out_valid;
  logic       out_ready;
  logic       err;
  logic [1:0] err_code;

  ascii_operand_parser dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_x(out_x), .out_y(out_y), .out_op(out_op), .out_valid(out_valid),
    .out_ready(out_ready), .err(err), .err_code(err_code)
  );

  typedef struct {
    bit         isErr;
    logic [1:0] code;
    logic [4:0] x;
    logic [4:0] y;
    logic       op;
  } ev_t;

  ev_t        expQ[$];
  logic [7:0] txQ[$];
  int         testCount = 0;
  int         failCount = 0;
  bit         randReady = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic expectFrame(input int x, input int y, input int op);
    ev_t e;
    e.isErr = 0; e.code = 0; e.x = 5'(x); e.y = 5'(y); e.op = op[0];
    expQ.push_back(e);
  endtask

  task automatic expectErr(input int code);
    ev_t e;
    e.isErr = 1; e.code = 2'(code); e.x = 0; e.y = 0; e.op = 0;
    expQ.push_back(e);
  endtask

  task automatic pushStr(input string s);
    for (int i = 0; i < s.len(); i++) txQ.push_back(s[i]);
  endtask

  function automatic logic [7:0] randByte(input bit noDigit, input bit noOp);
    logic [7:0] b;
    do begin
      b = 8'($urandom_range(32, 126));
    end while ((noDigit && b >= 8'h30 && b <= 8'h39) || (noOp && (b == 8'h2B || b == 8'h2D)));
    return b;
  endfunction

  // One random frame: either well-formed (possibly with CRs) or broken at a random field.
  task automatic genFrame();
    logic [7:0] f[8];
    logic [7:0] bad;
    int x, y, op, p, kind, code, t, u;
    x = $urandom_range(0, 15);
    y = $urandom_range(0, 15);
    op = $urandom_range(0, 1);
    f[0] = 8'h30 + 8'(x / 10); f[1] = 8'h30 + 8'(x % 10); f[2] = 8'h0A;
    f[3] = 8'h30 + 8'(y / 10); f[4] = 8'h30 + 8'(y % 10); f[5] = 8'h0A;
    f[6] = (op == 1) ? 8'h2D : 8'h2B; f[7] = 8'h0A;
    if ($urandom_range(0, 2) != 0) begin
      for (int i = 0; i < 8; i++) begin
        txQ.push_back(f[i]);
        if ($urandom_range(0, 5) == 0) txQ.push_back(8'h0D);
      end
      expectFrame(x, y, op);
    end else begin
      p = $urandom_range(0, 7);
      for (int i = 0; i < p; i++) txQ.push_back(f[i]);
      kind = $urandom_range(0, 2);
      case (p)
        0, 3: begin
          bad = (kind == 0) ? 8'h0A : randByte(1, 0);
          code = 1;
        end
        1, 4: begin
          if (kind == 0) begin
            bad = 8'h0A; code = 1;
          end else if (kind == 1) begin
            bad = randByte(1, 0); code = 1;
          end else begin
            t = $urandom_range(1, 9);
            u = (t == 1) ? $urandom_range(6, 9) : $urandom_range(0, 9);
            txQ[txQ.size() - 1] = 8'h30 + 8'(t);
            bad = 8'h30 + 8'(u); code = 2;
          end
        end
        6: begin
          bad = (kind == 0) ? 8'h0A : randByte(0, 1);
          code = 3;
        end
        default: begin
          bad = randByte(0, 0);
          code = 3;
        end
      endcase
      txQ.push_back(bad);
      expectErr(code);
      if (bad != 8'h0A) begin
        t = $urandom_range(0, 3);
        for (int i = 0; i < t; i++) txQ.push_back(($urandom_range(0, 4) == 0) ? 8'h0D : randByte(0, 0));
        txQ.push_back(8'h0A);
      end
    end
  endtask

  // Feeds txQ with random in_valid gaps; a byte leaves the queue only when it was accepted.
  task automatic applyStimulus();
    bit took;
    int guard = 0;
    @(posedge clk); #1;
    while (txQ.size() != 0 && guard < 20000) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = txQ[0];
      @(negedge clk);
      took = in_valid && in_ready;
      @(posedge clk); #1;
      if (took) void'(txQ.pop_front());
      guard++;
    end
    checkOutput("tx_timeout", txQ.size(), 0);
    txQ.delete();
    in_valid = 0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (expQ.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    checkOutput("drain", expQ.size(), 0);
    expQ.delete();
    repeat (3) @(posedge clk);
  endtask

  initial begin
    out_ready = 0;
    forever begin
      @(posedge clk); #1;
      if (randReady) out_ready = ($urandom_range(0, 2) != 0);
      else out_ready = 1;
    end
  end

  // Scoreboard: every err pulse and every presented frame must match the head of expQ.
  always @(negedge clk) begin
    if (!rst) begin
      if (err) begin
        if (expQ.size() == 0 || !expQ[0].isErr) checkOutput("unexpected_err", err, 0);
        else begin
          checkOutput("err_code", err_code, expQ[0].code);
          void'(expQ.pop_front());
        end
      end
      if (out_valid) begin
        checkOutput("in_ready_emit", in_ready, 0);
        if (expQ.size() == 0 || expQ[0].isErr) checkOutput("unexpected_valid", out_valid, 0);
        else begin
          checkOutput("out_x", out_x, expQ[0].x);
          checkOutput("out_y", out_y, expQ[0].y);
          checkOutput("out_op", out_op, expQ[0].op);
          if (out_ready) void'(expQ.pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1; in_valid = 0; in_data = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_out_x", out_x, 0);
    checkOutput("rst_out_y", out_y, 0);
    checkOutput("rst_out_op", out_op, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_err_code", err_code, 0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    checkOutput("idle_in_ready", in_ready, 1);

    pushStr("07\n12\n+\n");          expectFrame(7, 12, 0);
    pushStr("15\r\n15\n-\n");        expectFrame(15, 15, 1);
    pushStr("16\n03\n04\n-\n");      expectErr(2); expectFrame(3, 4, 1);
    pushStr("0a9\n05\n05\n+\n");     expectErr(1); expectFrame(5, 5, 0);
    applyStimulus();
    waitDrain();

    randReady = 1;
    for (int i = 0; i < 80; i++) genFrame();
    applyStimulus();
    waitDrain();

    pushStr("13\n11\n-\n");
    expectFrame(13, 11, 1);
    applyStimulus();
    waitDrain();

    pushStr("09\n1");
    applyStimulus();
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    checkOutput("midrst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    checkOutput("midrst_out_x", out_x, 0);
    checkOutput("midrst_out_y", out_y, 0);
    checkOutput("midrst_out_op", out_op, 0);
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_err_code", err_code, 0);
    pushStr("02\n03\n+\n");
    expectFrame(2, 3, 0);
    applyStimulus();
    waitDrain();

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/ascii_operand_parser.md
Name: ascii_operand_parser

Overview:
- Upstream front-end for the 5-bit add/subtract datapath.
- Consumes a byte stream of ASCII characters in the frame format "dd\n dd\n op\n": operand X, then operand Y, then '+' or '-'.
- Produces registered X, Y and Op (the carry-in/invert control) with a valid/ready handshake.
- Malformed frames are flagged with an error code and discarded by resynchronising on the next terminator.

Parameters:
- WIDTH, 5, output operand width in bits.
- MAX_VAL, 15, largest accepted two-digit operand value.
- TERM, 8'h0A, frame-field terminator byte (newline).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active high.
- in_data  input  8  ASCII byte.
- in_valid  input  1  in_data present.
- in_ready  output  1  parser can accept a byte.
- out_x  output  WIDTH  parsed X.
- out_y  output  WIDTH  parsed Y.
- out_op  output  1  0 = '+', 1 = '-'. Drives adder Op/C0.
- out_valid  output  1  out_x/out_y/out_op hold a complete frame.
- out_ready  input  1  consumer accepts the frame.
- err  output  1  one-cycle error pulse.
- err_code  output  2  1 = non-digit, 2 = value > MAX_VAL, 3 = bad op char or missing TERM. Holds its value until the next error or reset.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state X_D1; out_x = 0, out_y = 0, out_op = 0, out_valid = 0, err = 0, err_code = 0.
- in_ready is 0 while rst is high. It is combinationally 1 in every state except EMIT.
- A byte is consumed only on in_valid & in_ready.
- Byte 8'h0D (CR) is consumed and ignored in every state.
- State machine, advancing only on consumed bytes:
  - X_D1: digit ('0'..'9') -> store tens, go to X_D0.
  - X_D0: digit -> compute value = tens*10 + units; go to X_NL.
  - X_NL: TERM -> go to Y_D1.
  - Y_D1, Y_D0, Y_NL: identical to the X states, for Y.
  - OP: '+' (8'h2B) -> op = 0, go to OP_NL. '-' (8'h2D) -> op = 1, go to OP_NL.
  - OP_NL: TERM -> load outputs, go to EMIT.
- Arithmetic: value is computed at full precision (7 bits, max 99) and range-checked against MAX_VAL before truncation to WIDTH bits.
- Range failure: value > MAX_VAL is reported as err_code 2 at the X_D0 or Y_D0 byte.
- Errors:
  - Triggers: wrong character class in any state. Digit states give code 1. NL states and OP/OP_NL give code 3.
  - err pulses high for exactly one cycle, on the cycle after the offending byte is consumed. err_code updates in the same cycle.
  - Next state is FLUSH, unless the offending byte is TERM, in which case the next state is X_D1.
- FLUSH: discard bytes until TERM is consumed, then go to X_D1. The partial frame is dropped and the outputs keep their last emitted values.
- EMIT:
  - out_valid = 1, asserted the cycle after the final TERM is consumed (latency 1).
  - out_x, out_y and out_op are stable while out_valid = 1.
  - On out_valid & out_ready: out_valid = 0 next cycle, state goes to X_D1, and in_ready returns to 1 on that next cycle.
- Reset mid-frame: the partial frame is discarded. Outputs are reset as above and any pending out_valid is cleared.
- Simultaneous rst with any handshake: rst wins.

Optional Feature:
- Macro: PARSE_ERR_CNT_EN.
- Defined: adds output err_cnt[7:0].
  - Reset value 0.
  - Increments on each err pulse and saturates at 8'hFF.
  - Clears on a consumed byte 8'h1B (ESC) in any state. In that case the ESC byte also resets the FSM to X_D1 without an error.
- Undefined: no err_cnt port. ESC is an ordinary character, so it produces code 1 or 3 depending on state.

Test Plan:
1. Bytes "07\n12\n+\n", out_ready = 1 -> one cycle after the last '\n': out_valid = 1, out_x = 00111, out_y = 01100, out_op = 0. out_valid = 0 the following cycle.
2. Bytes "15\r\n15\n-\n" -> out_x = 01111, out_y = 01111, out_op = 1. The CR is ignored and err never pulses.
3. Bytes "16\n03\n04\n-\n" -> err pulse with err_code = 2 after the '6'. The "\n" is flushed. The next frame gives out_x = 00011, out_y = 00100, out_op = 1.
4. Bytes "0a9\n05\n05\n+\n" -> err with code 1 after 'a'. "9\n" is discarded in FLUSH. The output frame is x = 5, y = 5, op = 0.
5. Valid frame with out_ready held low for 5 cycles and in_valid held high with "01" -> in_ready = 0, outputs stable, no bytes consumed. When out_ready rises, the handshake completes and in_ready = 1 the next cycle.
6. rst asserted for one cycle after "09\n1" -> all outputs 0. The subsequent "02\n03\n+\n" yields x = 2, y = 3, op = 0 with no error.
